pwm_capture: RTL and testbench



---
 rtl/pwm_capture.sv | 176 +++++++++++++++++
 tb/tb_pwm_capture.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/pwm_capture.sv
// RC-style PWM pulse-width capture: recovers an 8-bit speed value from the
// high time of a 50 Hz servo/ESC pulse and flags loss of signal.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   enable       1 = capture active; 0 = held in ARM, counters cleared
//   pwm_in       asynchronous PWM input pin
//   speed        last accepted speed value
//   valid        one-cycle strobe when speed is updated
//   pulse_err    one-cycle strobe when a pulse is rejected
//   signal_lost  1 when no pulse has been accepted for TIMEOUT_CYCLES
module pwm_capture #(
    parameter int MIN_CYCLES     = 16000,
    parameter int STEP_CYCLES    = 62,
    parameter int GLITCH_CYCLES  = 8000,
    parameter int MAX_CYCLES     = 40000,
    parameter int TIMEOUT_CYCLES = 400000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       pwm_in,
    output logic [7:0] speed,
    output logic       valid,
    output logic       pulse_err,
    output logic       signal_lost
);

    localparam int CW = $clog2(MAX_CYCLES + 2);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int SW = $clog2(STEP_CYCLES + 1);

    localparam logic [CW-1:0] MinC    = CW'(MIN_CYCLES);
    localparam logic [CW-1:0] GlitchC = CW'(GLITCH_CYCLES);
    localparam logic [CW-1:0] MaxC    = CW'(MAX_CYCLES);
    localparam logic [SW-1:0] SubLast = SW'(STEP_CYCLES - 1);
    localparam logic [TW-1:0] TmoMax  = TW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {ARM, IDLE, MIN, STEP} state_t;

    state_t        state, stateNext;
    logic          s1, s2, prev;
    logic          rise, fall;
    logic [CW-1:0] highCnt, highNext, cntInc;
    logic [SW-1:0] sub, subNext;
    logic [7:0]    step, stepNext;
    logic [7:0]    speedNext;
    logic          validNext, errNext;
    logic [TW-1:0] tmo, tmoNext;
    logic          lostNext;

    // The synchroniser presets high so that a pulse still in progress when
    // reset releases looks like a line that was already high: ARM then waits
    // for its end instead of seeing a fresh rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1   <= 1'b1;
            s2   <= 1'b1;
            prev <= 1'b1;
        end else begin
            s1   <= pwm_in;
            s2   <= s1;
            prev <= s2;
        end
    end

    assign rise   = s2 & ~prev;
    assign fall   = ~s2 & prev;
    assign cntInc = highCnt + 1'b1;

    // highCnt counts s2-high clocks including the rise cycle, so at the
    // fall it equals the measured high time H.
    always_comb begin
        stateNext = state;
        highNext  = highCnt;
        subNext   = sub;
        stepNext  = step;
        speedNext = speed;
        validNext = 1'b0;
        errNext   = 1'b0;
        if (!enable) begin
            stateNext = ARM;
            highNext  = '0;
            subNext   = '0;
            stepNext  = '0;
        end else begin
            unique case (state)
                ARM: begin
                    if (!s2) stateNext = IDLE;
                end
                IDLE: begin
                    if (rise) begin
                        highNext  = CW'(1);
                        subNext   = '0;
                        stepNext  = '0;
                        stateNext = MIN;
                    end
                end
                MIN: begin
                    if (fall) begin
                        stateNext = IDLE;
                        if (highCnt < GlitchC) begin
                            errNext = 1'b1;
                        end else begin
                            validNext = 1'b1;
                            speedNext = 8'd0;
                        end
                    end else begin
                        highNext = cntInc;
                        if (cntInc == MinC) begin
                            stateNext = STEP;
                            subNext   = '0;
                            stepNext  = '0;
                        end
                    end
                end
                STEP: begin
                    if (fall) begin
                        stateNext = IDLE;
                        validNext = 1'b1;
                        speedNext = step;
                    end else begin
                        highNext = cntInc;
                        if (cntInc > MaxC) begin
                            errNext   = 1'b1;
                            stateNext = ARM;
                        end else if (sub == SubLast) begin
                            subNext = '0;
                            if (step != 8'hFF) stepNext = step + 8'd1;
                        end else begin
                            subNext = sub + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    always_comb begin
        tmoNext  = tmo;
        lostNext = signal_lost;
        if (validNext) begin
            tmoNext  = '0;
            lostNext = 1'b0;
        end else if (enable && tmo != TmoMax) begin
            tmoNext = tmo + 1'b1;
            if (tmoNext == TmoMax) lostNext = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ARM;
            highCnt     <= '0;
            sub         <= '0;
            step        <= '0;
            speed       <= '0;
            valid       <= 1'b0;
            pulse_err   <= 1'b0;
            tmo         <= '0;
            signal_lost <= 1'b1;
        end else begin
            state       <= stateNext;
            highCnt     <= highNext;
            sub         <= subNext;
            step        <= stepNext;
            speed       <= speedNext;
            valid       <= validNext;
            pulse_err   <= errNext;
            tmo         <= tmoNext;
            signal_lost <= lostNext;
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// Scoreboard bench for pwm_capture with scaled-down timing parameters.
// Stimulus pushes expected events; a negedge monitor pops and compares.
module tb_pwm_capture;

    localparam int MINC  = 100;
    localparam int STEPC = 2;
    localparam int GLC   = 50;
    localparam int MAXC  = 700;
    localparam int TMOC  = 2000;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic       pwm_in;
    logic [7:0] speed;
    logic       valid;
    logic       pulse_err;
    logic       signal_lost;

    typedef struct packed {
        logic       isErr;
        logic [7:0] spd;
    } exp_t;

    exp_t expQ[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   lastValidCyc = 0;
    logic [7:0] prevSpeed = 8'd0;

    pwm_capture #(
        .MIN_CYCLES(MINC),
        .STEP_CYCLES(STEPC),
        .GLITCH_CYCLES(GLC),
        .MAX_CYCLES(MAXC),
        .TIMEOUT_CYCLES(TMOC)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .enable(enable),
        .pwm_in(pwm_in),
        .speed(speed),
        .valid(valid),
        .pulse_err(pulse_err),
        .signal_lost(signal_lost)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (valid || pulse_err) begin
                checks++;
                if (valid && pulse_err) begin
                    errors++;
                    $display("FAIL strobe_excl: valid=%0b pulse_err=%0b both set",
                             valid, pulse_err);
                end else if (expQ.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected: valid=%0b err=%0b speed=%0d, none expected",
                             valid, pulse_err, speed);
                end else begin
                    e = expQ.pop_front();
                    if (e.isErr != pulse_err || (valid && speed != e.spd)) begin
                        errors++;
                        $display("FAIL event: got err=%0b speed=%0d, want err=%0b speed=%0d",
                                 pulse_err, speed, e.isErr, e.spd);
                    end
                end
                if (valid) begin
                    checks++;
                    lastValidCyc = cyc;
                    if (signal_lost) begin
                        errors++;
                        $display("FAIL lost_on_valid: signal_lost=%0b want 0", signal_lost);
                    end
                end
            end
            if (!valid) begin
                checks++;
                if (speed != prevSpeed) begin
                    errors++;
                    $display("FAIL speed_hold: speed=%0d was %0d without valid",
                             speed, prevSpeed);
                end
            end
        end
        prevSpeed = speed;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic pulse(input int h, input bit isErr, input logic [7:0] spd,
                         input int gap);
        exp_t e;
        e.isErr = isErr;
        e.spd   = spd;
        expQ.push_back(e);
        @(negedge clk);
        pwm_in = 1'b1;
        repeat (h) @(negedge clk);
        pwm_in = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic drained(input string name);
        repeat (8) @(negedge clk);
        chk(name, expQ.size(), 0);
    endtask

    initial begin
        int n;
        rst_n  = 1'b0;
        enable = 1'b1;
        pwm_in = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_speed", speed, 0);
        chk("rst_valid", valid, 0);
        chk("rst_err", pulse_err, 0);
        chk("rst_lost", signal_lost, 1);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        pulse(100, 1'b0, 8'd0, 20);
        chk("lost_cleared", signal_lost, 0);
        pulse(150, 1'b0, 8'd25, 20);
        pulse(700, 1'b0, 8'd255, 20);
        pulse(609, 1'b0, 8'd254, 20);
        pulse(10, 1'b1, 8'd0, 20);
        pulse(75, 1'b0, 8'd0, 20);
        pulse(49, 1'b1, 8'd0, 20);
        pulse(50, 1'b0, 8'd0, 20);
        pulse(103, 1'b0, 8'd1, 20);
        pulse(101, 1'b0, 8'd0, 20);
        pulse(150, 1'b0, 8'd25, 20);
        pulse(900, 1'b1, 8'd0, 20);
        pulse(150, 1'b0, 8'd25, 20);
        pulse(701, 1'b1, 8'd0, 20);
        drained("drain_basic");
        chk("speed_after_rej", speed, 25);

        @(negedge clk);
        pwm_in = 1'b1;
        repeat (30) @(negedge clk);
        enable = 1'b0;
        repeat (20) @(negedge clk);
        chk("en_speed_hold", speed, 25);
        enable = 1'b1;
        repeat (100) @(negedge clk);
        pwm_in = 1'b0;
        drained("drain_enable");
        pulse(700, 1'b0, 8'd255, 20);

        @(negedge clk);
        pwm_in = 1'b1;
        repeat (30) @(negedge clk);
        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        chk("mid_rst_speed", speed, 0);
        chk("mid_rst_lost", signal_lost, 1);
        chk("mid_rst_valid", valid, 0);
        rst_n = 1'b1;
        repeat (115) @(negedge clk);
        pwm_in = 1'b0;
        drained("drain_reset");
        pulse(150, 1'b0, 8'd25, 20);

        pulse(100, 1'b0, 8'd0, 300);
        pulse(100, 1'b0, 8'd0, 300);
        pulse(100, 1'b0, 8'd0, 300);
        chk("lost_low_spaced", signal_lost, 0);
        n = 0;
        while (!signal_lost && n < 3 * TMOC) begin
            @(negedge clk);
            n++;
        end
        chk("lost_raised", signal_lost, 1);
        chk("timeout_cycles", cyc - lastValidCyc, TMOC);
        pulse(100, 1'b0, 8'd0, 20);
        chk("lost_recover", signal_lost, 0);
        drained("drain_end");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
